// File: rtl/spmp_region_encoder_if.sv
// rtl/spmp_region_encoder_if.sv - request, CSR-write and response ports of the SPMP region encoder
interface spmp_region_encoder_if #(
    parameter int PLEN       = 56,
    parameter int NR_ENTRIES = 16
);
    localparam int IDXW = $clog2(NR_ENTRIES);

    logic              req_valid_i;
    logic              req_ready_o;
    logic [PLEN-1:0]   req_base_i;
    logic [PLEN-1:0]   req_size_i;
    logic [IDXW:0]     req_idx_i;
    logic [2:0]        req_perm_i;

    logic              csr_wr_valid_o;
    logic              csr_wr_ready_i;
    logic              csr_wr_is_cfg_o;
    logic [IDXW-1:0]   csr_wr_idx_o;
    logic [PLEN-3:0]   csr_wr_data_o;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_err_o;
    logic [1:0]        rsp_mode_o;
    logic [1:0]        rsp_entries_o;

    modport slave (
        input  req_valid_i, req_base_i, req_size_i, req_idx_i, req_perm_i,
        output req_ready_o,
        output csr_wr_valid_o, csr_wr_is_cfg_o, csr_wr_idx_o, csr_wr_data_o,
        input  csr_wr_ready_i,
        output rsp_valid_o, rsp_err_o, rsp_mode_o, rsp_entries_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_base_i, req_size_i, req_idx_i, req_perm_i,
        input  req_ready_o,
        input  csr_wr_valid_o, csr_wr_is_cfg_o, csr_wr_idx_o, csr_wr_data_o,
        output csr_wr_ready_i,
        input  rsp_valid_o, rsp_err_o, rsp_mode_o, rsp_entries_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/spmp_region_encoder.sv
// rtl/spmp_region_encoder.sv - region request to SPMP NA4/NAPOT/TOR CSR writes; TOR fallback under SPMP_REGION_ENC_TOR_EN
module spmp_region_encoder #(
    parameter int PLEN       = 56,
    parameter int NR_ENTRIES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spmp_region_encoder_if.slave  bus
);
    localparam int IDXW = $clog2(NR_ENTRIES);
    localparam int AW   = PLEN - 2;

    localparam logic [1:0]      MODE_OFF   = 2'd0;
    localparam logic [1:0]      MODE_TOR   = 2'd1;
    localparam logic [1:0]      MODE_NA4   = 2'd2;
    localparam logic [1:0]      MODE_NAPOT = 2'd3;
    localparam logic [IDXW:0]   IDX_LIMIT  = (IDXW+1)'(NR_ENTRIES);
    localparam logic [IDXW-1:0] IDX_ONE    = IDXW'(1);
    localparam logic [PLEN-1:0] SZ_ONE     = PLEN'(1);
    localparam logic [PLEN-1:0] SZ_FOUR    = PLEN'(4);
    localparam logic [PLEN-1:0] SZ_EIGHT   = PLEN'(8);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLASSIFY = 3'd1,
`ifdef SPMP_REGION_ENC_TOR_EN
        S_WR_PREV  = 3'd2,
`endif
        S_WR_ADDR  = 3'd3,
        S_WR_CFG   = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [PLEN-1:0] r_base;
    logic [PLEN-1:0] r_size;
    logic [IDXW:0]   r_idx;
    logic [2:0]      r_perm;
    logic            r_err;
    logic [1:0]      r_mode;
    logic [1:0]      r_entries;
    logic [AW-1:0]   r_addr;

    logic [PLEN-1:0] w_size_m1;
    logic [PLEN-1:0] w_napot_full;
    logic            w_bad;
    logic            w_na4;
    logic            w_napot;
    logic            w_cls_err;
    logic [1:0]      w_cls_mode;
    logic [1:0]      w_cls_entries;
    logic [AW-1:0]   w_cls_addr;
    logic            w_unused;

`ifdef SPMP_REGION_ENC_TOR_EN
    logic [AW-1:0]   r_prev;
    logic            r_use_prev;
    logic [PLEN:0]   w_top;
    logic [AW-1:0]   w_cls_prev;
    logic            w_cls_use_prev;

    assign w_top    = {1'b0, r_base} + {1'b0, r_size};
    assign w_unused = ^{w_top[1:0], w_napot_full[PLEN-1:AW]};
`else
    assign w_unused = ^w_napot_full[PLEN-1:AW];
`endif

    assign w_size_m1    = r_size - SZ_ONE;
    assign w_bad        = (r_size == '0) || (r_base[1:0] != 2'b00) || (r_size[1:0] != 2'b00)
                          || (r_idx >= IDX_LIMIT);
    assign w_na4        = (r_size == SZ_FOUR);
    assign w_napot      = ((r_size & w_size_m1) == '0) && (r_size >= SZ_EIGHT)
                          && ((r_base & w_size_m1) == '0);
    // Size is a power of two here, so OR-ing the low ones never disturbs the aligned base bits.
    assign w_napot_full = {2'b00, r_base[PLEN-1:2]} | ((r_size >> 3) - SZ_ONE);

    always_comb begin
        w_cls_err     = 1'b1;
        w_cls_mode    = MODE_OFF;
        w_cls_entries = 2'd0;
        w_cls_addr    = '0;
`ifdef SPMP_REGION_ENC_TOR_EN
        w_cls_prev     = '0;
        w_cls_use_prev = 1'b0;
`endif
        if (w_bad) begin
            w_cls_err = 1'b1;
        end else if (w_na4) begin
            w_cls_err     = 1'b0;
            w_cls_mode    = MODE_NA4;
            w_cls_entries = 2'd1;
            w_cls_addr    = r_base[PLEN-1:2];
        end else if (w_napot) begin
            w_cls_err     = 1'b0;
            w_cls_mode    = MODE_NAPOT;
            w_cls_entries = 2'd1;
            w_cls_addr    = w_napot_full[AW-1:0];
        end else begin
`ifdef SPMP_REGION_ENC_TOR_EN
            // Entry 0 has an implicit lower bound of zero, so only base 0 can be expressed there.
            if (!w_top[PLEN] && !((r_idx == '0) && (r_base != '0))) begin
                w_cls_err      = 1'b0;
                w_cls_mode     = MODE_TOR;
                w_cls_addr     = w_top[PLEN-1:2];
                w_cls_prev     = r_base[PLEN-1:2];
                w_cls_use_prev = (r_idx != '0);
                w_cls_entries  = (r_idx != '0) ? 2'd2 : 2'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state           = r_state;
        bus.req_ready_o        = 1'b0;
        bus.csr_wr_valid_o     = 1'b0;
        bus.csr_wr_is_cfg_o    = 1'b0;
        bus.csr_wr_idx_o       = '0;
        bus.csr_wr_data_o      = '0;
        bus.rsp_valid_o        = 1'b0;
        bus.rsp_err_o          = 1'b0;
        bus.rsp_mode_o         = MODE_OFF;
        bus.rsp_entries_o      = 2'd0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    w_next_state = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                if (w_cls_err) begin
                    w_next_state = S_RESP;
`ifdef SPMP_REGION_ENC_TOR_EN
                end else if (w_cls_use_prev) begin
                    w_next_state = S_WR_PREV;
`endif
                end else begin
                    w_next_state = S_WR_ADDR;
                end
            end
`ifdef SPMP_REGION_ENC_TOR_EN
            S_WR_PREV: begin
                bus.csr_wr_valid_o = 1'b1;
                bus.csr_wr_idx_o   = r_idx[IDXW-1:0] - IDX_ONE;
                bus.csr_wr_data_o  = r_prev;
                if (bus.csr_wr_ready_i) begin
                    w_next_state = S_WR_ADDR;
                end
            end
`endif
            S_WR_ADDR: begin
                bus.csr_wr_valid_o = 1'b1;
                bus.csr_wr_idx_o   = r_idx[IDXW-1:0];
                bus.csr_wr_data_o  = r_addr;
                if (bus.csr_wr_ready_i) begin
                    w_next_state = S_WR_CFG;
                end
            end
            S_WR_CFG: begin
                bus.csr_wr_valid_o  = 1'b1;
                bus.csr_wr_is_cfg_o = 1'b1;
                bus.csr_wr_idx_o    = r_idx[IDXW-1:0];
                bus.csr_wr_data_o   = {{(AW-8){1'b0}}, 3'b000, r_mode, r_perm};
                if (bus.csr_wr_ready_i) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid_o   = 1'b1;
                bus.rsp_err_o     = r_err;
                bus.rsp_mode_o    = r_mode;
                bus.rsp_entries_o = r_entries;
                if (bus.rsp_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_base    <= '0;
            r_size    <= '0;
            r_idx     <= '0;
            r_perm    <= '0;
            r_err     <= 1'b0;
            r_mode    <= MODE_OFF;
            r_entries <= 2'd0;
            r_addr    <= '0;
`ifdef SPMP_REGION_ENC_TOR_EN
            r_prev     <= '0;
            r_use_prev <= 1'b0;
`endif
        end else begin
            if ((r_state == S_IDLE) && bus.req_valid_i) begin
                r_base <= bus.req_base_i;
                r_size <= bus.req_size_i;
                r_idx  <= bus.req_idx_i;
                r_perm <= bus.req_perm_i;
            end
            if (r_state == S_CLASSIFY) begin
                r_err     <= w_cls_err;
                r_mode    <= w_cls_mode;
                r_entries <= w_cls_entries;
                r_addr    <= w_cls_addr;
`ifdef SPMP_REGION_ENC_TOR_EN
                r_prev     <= w_cls_prev;
                r_use_prev <= w_cls_use_prev;
`endif
            end
        end
    end
endmodule

// File: tb/tb_spmp_region_encoder.sv
// tb/tb_spmp_region_encoder.sv - self-checking bench for spmp_region_encoder against a behavioural region model
module tb_spmp_region_encoder;
    localparam int PLEN = 56;
    localparam int NR   = 16;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    spmp_region_encoder_if #(.PLEN(PLEN), .NR_ENTRIES(NR)) bus();

    spmp_region_encoder #(.PLEN(PLEN), .NR_ENTRIES(NR)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int wr_stall = 0;
    int rsp_stall = 0;
    int stab_err = 0;
    int rsp_count = 0;

    logic [63:0] got_wr[$];
    logic        got_err;
    logic [1:0]  got_mode;
    logic [1:0]  got_entries;
    logic [63:0] exp_wr[$];
    logic        exp_err;
    logic [1:0]  exp_mode;
    logic [1:0]  exp_entries;

    function automatic logic [63:0] pack_wr(input logic is_cfg, input logic [3:0] idx, input logic [63:0] data);
        return {5'd0, is_cfg, idx, data[53:0]};
    endfunction

    function automatic logic [63:0] got_at(input int i);
        if (i < got_wr.size()) return got_wr[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Region rules stated directly as arithmetic on byte addresses.
    function automatic void model(input logic [63:0] base, input logic [63:0] size, input int idx, input logic [2:0] perm);
        int          mode;
        logic [63:0] addr;
        logic [63:0] top;
        exp_wr.delete();
        exp_err = 1'b1;
        exp_mode = 2'd0;
        exp_entries = 2'd0;
        top = base + size;
        if (size == 0 || base % 4 != 0 || size % 4 != 0 || idx >= NR) return;
        if (size == 4) begin
            mode = 2;
            addr = base / 4;
        end else if ($countones(size) == 1 && size >= 8 && base % size == 0) begin
            mode = 3;
            addr = base / 4 + size / 8 - 1;
        end else begin
`ifdef SPMP_REGION_ENC_TOR_EN
            if (top >= (64'd1 << PLEN)) return;
            if (idx == 0 && base != 0) return;
            mode = 1;
            if (idx > 0) exp_wr.push_back(pack_wr(1'b0, 4'(idx - 1), base / 4));
            addr = top / 4;
`else
            return;
`endif
        end
        exp_wr.push_back(pack_wr(1'b0, 4'(idx), addr));
        exp_wr.push_back(pack_wr(1'b1, 4'(idx), 64'(mode * 8 + int'(perm))));
        exp_err = 1'b0;
        exp_mode = 2'(mode);
        exp_entries = 2'(exp_wr.size() - 1);
    endfunction

    // Sink side: applies back-pressure, logs accepted writes/responses, tracks stability while stalled.
    initial begin : mon
        int          wcnt;
        int          rcnt;
        bit          whold;
        bit          rhold;
        logic [63:0] wprev;
        logic [63:0] wcur;
        logic [4:0]  rprev;
        logic [4:0]  rcur;
        wcnt = 0; rcnt = 0; whold = 0; rhold = 0; wprev = '0; rprev = '0;
        forever begin
            @(negedge clk);
            if (bus.csr_wr_valid_o) begin
                wcur = pack_wr(bus.csr_wr_is_cfg_o, bus.csr_wr_idx_o, 64'(bus.csr_wr_data_o));
                if (whold && wcur !== wprev) stab_err++;
                wprev = wcur;
                if (wcnt < wr_stall) begin
                    bus.csr_wr_ready_i = 1'b0; wcnt++; whold = 1;
                end else begin
                    bus.csr_wr_ready_i = 1'b1; wcnt = 0; whold = 0;
                    got_wr.push_back(wcur);
                end
            end else begin
                bus.csr_wr_ready_i = 1'b1; wcnt = 0; whold = 0;
            end
            if (bus.rsp_valid_o) begin
                rcur = {bus.rsp_err_o, bus.rsp_mode_o, bus.rsp_entries_o};
                if (rhold && rcur !== rprev) stab_err++;
                rprev = rcur;
                if (rcnt < rsp_stall) begin
                    bus.rsp_ready_i = 1'b0; rcnt++; rhold = 1;
                end else begin
                    bus.rsp_ready_i = 1'b1; rcnt = 0; rhold = 0;
                    {got_err, got_mode, got_entries} = rcur;
                    rsp_count++;
                end
            end else begin
                bus.rsp_ready_i = 1'b1; rcnt = 0; rhold = 0;
            end
        end
    end

    task automatic do_req(input logic [63:0] base, input logic [63:0] size, input int idx, input logic [2:0] perm,
                          input string tag, input bit chk_lat, output int gb);
        int c0, n, lat, rdy_bad;
        model(base, size, idx, perm);
        gb = got_wr.size();
        c0 = rsp_count;
        @(negedge clk);
        bus.req_base_i = base[PLEN-1:0];
        bus.req_size_i = size[PLEN-1:0];
        bus.req_idx_i = 5'(idx);
        bus.req_perm_i = perm;
        bus.req_valid_i = 1'b1;
        chk($sformatf("%s_req_ready", tag), bus.req_ready_o, 1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        lat = -1; rdy_bad = 0; n = 0;
        while (rsp_count == c0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.req_ready_o) rdy_bad++;
            if (lat < 0 && bus.rsp_valid_o) lat = n - 1;
        end
        chk($sformatf("%s_done", tag), rsp_count != c0, 1);
        chk($sformatf("%s_err", tag), got_err, exp_err);
        chk($sformatf("%s_mode", tag), got_mode, exp_mode);
        chk($sformatf("%s_entries", tag), got_entries, exp_entries);
        chk($sformatf("%s_nwr", tag), got_wr.size() - gb, exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), got_at(gb + i), exp_wr[i]);
        chk($sformatf("%s_busy_ready_low", tag), rdy_bad, 0);
        if (chk_lat) chk($sformatf("%s_latency", tag), lat, 1 + exp_wr.size());
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    logic [63:0] err_base [5] = '{64'h1000, 64'h2, 64'h1000, 64'h100, 64'h00FF_FFFF_FFFF_F000};
    logic [63:0] err_size [5] = '{64'h6, 64'h4, 64'h4, 64'h300, 64'h2000};
    int          err_idx  [5] = '{1, 1, 16, 0, 4};

    initial begin : main
        int          gb;
        int          s0;
        int          c0;
        int          n;
        int          cat;
        int          k;
        logic [63:0] b;
        logic [63:0] s;
        bus.req_valid_i = 1'b0;
        bus.req_base_i = '0;
        bus.req_size_i = '0;
        bus.req_idx_i = '0;
        bus.req_perm_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_wr_valid", bus.csr_wr_valid_o, 0);
        chk("rst_wr_fields", {bus.csr_wr_is_cfg_o, bus.csr_wr_idx_o, bus.csr_wr_data_o}, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_fields", {bus.rsp_err_o, bus.rsp_mode_o, bus.rsp_entries_o}, 0);
        rst_ni = 1'b1;

        do_req(64'h8000_0010, 64'h4, 3, 3'b011, "na4", 1, gb);
        chk("na4_addr_const", got_at(gb), pack_wr(1'b0, 4'd3, 64'h2000_0004));
        chk("na4_cfg_const", got_at(gb + 1), pack_wr(1'b1, 4'd3, 64'h13));

        do_req(64'h8000_0000, 64'h1000, 5, 3'b111, "napot", 1, gb);
        chk("napot_addr_const", got_at(gb), pack_wr(1'b0, 4'd5, 64'h2000_01FF));
        chk("napot_cfg_const", got_at(gb + 1), pack_wr(1'b1, 4'd5, 64'h1F));

        do_req(64'h8, 64'h8, 1, 3'b001, "napot8", 1, gb);
        chk("napot8_addr_const", got_at(gb), pack_wr(1'b0, 4'd1, 64'h2));

        do_req(64'h8000_1000, 64'h3000, 2, 3'b001, "tor", 1, gb);
`ifdef SPMP_REGION_ENC_TOR_EN
        chk("tor_prev_const", got_at(gb), pack_wr(1'b0, 4'd1, 64'h2000_0400));
        chk("tor_addr_const", got_at(gb + 1), pack_wr(1'b0, 4'd2, 64'h2000_1000));
        chk("tor_cfg_const", got_at(gb + 2), pack_wr(1'b1, 4'd2, 64'h09));
        chk("tor_entries_const", got_entries, 2);
`else
        chk("tor_off_err_const", got_err, 1);
        chk("tor_off_nwr_const", got_wr.size() - gb, 0);
`endif

        for (int i = 0; i < 5; i++)
            do_req(err_base[i], err_size[i], err_idx[i], 3'b011, $sformatf("errcase%0d", i), 1, gb);

        wr_stall = 5;
        rsp_stall = 3;
        s0 = stab_err;
`ifdef SPMP_REGION_ENC_TOR_EN
        do_req(64'h8000_1000, 64'h3000, 2, 3'b001, "bp", 0, gb);
        chk("bp_three_writes", got_wr.size() - gb, 3);
`else
        do_req(64'h4000, 64'h4000, 7, 3'b101, "bp", 0, gb);
`endif
        chk("bp_stable", stab_err - s0, 0);
        wr_stall = 0;
        rsp_stall = 0;

        wr_stall = 1000;
        c0 = rsp_count;
        gb = got_wr.size();
        @(negedge clk);
        bus.req_base_i = 56'h40;
        bus.req_size_i = 56'h4;
        bus.req_idx_i = 5'd9;
        bus.req_perm_i = 3'b001;
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        n = 0;
        while (!(bus.csr_wr_valid_o && !bus.csr_wr_is_cfg_o) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reached_wr_addr", bus.csr_wr_valid_o && !bus.csr_wr_is_cfg_o, 1);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_wr_valid", bus.csr_wr_valid_o, 0);
        chk("rst_mid_req_ready", bus.req_ready_o, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        wr_stall = 0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_count - c0, 0);
        chk("rst_mid_no_wr", got_wr.size() - gb, 0);
        do_req(64'h8000_0010, 64'h4, 3, 3'b011, "post_rst_na4", 1, gb);

        for (int it = 0; it < 40; it++) begin
            cat = $urandom_range(0, 4);
            k = $urandom_range(2, 24);
            b = {$urandom, $urandom} & 64'h00FF_FFFF_FFFF_FFFF;
            case (cat)
                0: begin s = 64'h4; b = b & ~64'h3; end
                1: begin s = 64'd1 << k; b = b & ~(s - 1); end
                2: begin s = 64'($urandom_range(1, 4096)) * 4; b = b & ~64'h3; end
                3: begin s = 64'($urandom_range(0, 64)); b = b & 64'hFFFF_FFFF; end
                default: begin b = 64'h00FF_FFFF_FFFF_F000; s = 64'd1 << $urandom_range(10, 16); end
            endcase
            wr_stall = $urandom_range(0, 2);
            rsp_stall = $urandom_range(0, 2);
            do_req(b, s, $urandom_range(0, 17), 3'($urandom), $sformatf("rnd%0d", it), 0, gb);
        end
        wr_stall = 0;
        rsp_stall = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spmp_region_encoder.md
Name: spmp_region_encoder

Overview:
- Converts a software-level region request (base, size, permissions, entry index) into SPMP CSR programming.
- Selects NA4, NAPOT or TOR encoding, computes the spmpaddr/spmpcfg values, and issues them as sequential CSR writes over a valid/ready write port.
- Acts as the encode-side counterpart of the per-entry SPMP match logic.
- Sits between the region-setup agent (debug/firmware assist) and the SPMP CSR file.

Parameters:
- PLEN, 56, physical address width; spmpaddr width is PLEN-2.
- NR_ENTRIES, 16, number of SPMP entries; IDXW = $clog2(NR_ENTRIES).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  region request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_base_i  in  PLEN  region base byte address
- req_size_i  in  PLEN  region size in bytes
- req_idx_i  in  IDXW+1  target entry index (extra bit detects out-of-range)
- req_perm_i  in  3  {X,W,R}
- csr_wr_valid_o  out  1  CSR write valid
- csr_wr_ready_i  in  1  CSR write accepted
- csr_wr_is_cfg_o  out  1  1=spmpcfg write, 0=spmpaddr write
- csr_wr_idx_o  out  IDXW  entry index of write
- csr_wr_data_o  out  PLEN-2  addr value, or cfg in [7:0] with upper bits zero
- rsp_valid_o  out  1  completion valid
- rsp_ready_i  in  1  completion accepted
- rsp_err_o  out  1  request rejected, no writes issued
- rsp_mode_o  out  2  chosen mode: OFF=0, TOR=1, NA4=2, NAPOT=3
- rsp_entries_o  out  2  spmpaddr entries written (0, 1 or 2)

Behaviour:
- Clock/reset: clk_i single clock; rst_ni synchronous, active-low.
- Reset state: IDLE. All outputs 0 except req_ready_o=1.
- FSM states: IDLE, CLASSIFY, WR_PREV, WR_ADDR, WR_CFG, RESP.
- IDLE:
  - req_ready_o=1 only here.
  - On accept, register the request and go to CLASSIFY.
- CLASSIFY: single cycle, registered result, evaluated in this priority:
  - Error if size==0, base[1:0]!=0, size[1:0]!=0, or idx>=NR_ENTRIES.
  - NA4 if size==4: addr = base>>2.
  - NAPOT if size is a power of two, size>=8, and (base & (size-1))==0: addr = (base>>2) | ((size>>3)-1).
  - Otherwise TOR, with top = base+size computed in PLEN+1 bits:
    - Error if top >= 2^PLEN.
    - Error if idx==0 and base!=0.
    - Otherwise prev = base>>2 and addr = top>>2.
  - Any error goes straight to RESP with err=1, mode=OFF, entries=0.
- TOR with idx>0: WR_PREV writes spmpaddr[idx-1]=prev. spmpcfg[idx-1] is never touched; the caller guarantees it is OFF.
- WR_ADDR: writes spmpaddr[idx]=addr.
- WR_CFG: writes spmpcfg[idx] = {3'b000, mode[1:0], perm[2:0]}.
- Write order is fixed: PREV (if used), ADDR, CFG.
- Each write state:
  - Holds csr_wr_valid_o=1 with idx/data/is_cfg stable until csr_wr_ready_i.
  - Advances on the same cycle as ready.
  - No bubble is required between writes.
- RESP: holds rsp_valid_o and its fields stable until rsp_ready_i, then returns to IDLE. A new request can be accepted the cycle after.
- Minimum latency with ready always high: accept to rsp_valid_o is 3 cycles for NA4/NAPOT (4 for TOR with prev).
- Reset asserted in any state: next edge returns to IDLE; in-flight writes and response are dropped with no partial completion reported.
- Arithmetic: all shifts are logical. Power-of-two test is (size & (size-1))==0.

Optional Feature:
- Macro: SPMP_REGION_ENC_TOR_EN.
- Defined: TOR fallback as described above.
- Undefined:
  - Requests that are neither NA4 nor NAPOT return err=1 with no writes.
  - WR_PREV state and the PLEN+1 adder are removed.
  - rsp_entries_o is never 2.

Test Plan:
- NA4: base 0x8000_0010, size 4, idx 3, perm 3'b011 -> addr[3]=0x2000_0004, then cfg[3]=0x13; rsp mode=2, entries=1, err=0.
- NAPOT: base 0x8000_0000, size 0x1000, idx 5, perm 3'b111 -> addr[5]=0x2000_01FF, cfg[5]=0x1F; mode=3. Also size 8 at base 0x8 -> addr=0x2.
- TOR (macro on): base 0x8000_1000, size 0x3000, idx 2, perm 3'b001 -> addr[1]=0x2000_0400, addr[2]=0x2000_1000, cfg[2]=0x09 in that order; mode=1, entries=2. Macro off -> err=1, no writes.
- Backpressure: hold csr_wr_ready_i low 5 cycles at each write and rsp_ready_i low 3 cycles -> valid and data stable throughout, exactly 3 writes, req_ready_o=0 until after the response.
- Errors -> err=1, zero CSR writes:
  - size 6
  - base 0x2
  - idx 16
  - idx 0 TOR with base 0x100, size 0x300
  - base 0xFF..F000, size 0x2000 (overflow)
- Reset: drop rst_ni during WR_ADDR with ready low -> next cycle csr_wr_valid_o=0, req_ready_o=1; a following NA4 request completes normally.
